ingress_ram_writer: RTL and testbench

// - Per-port ingress stage directly upstream of the switch scheduler.
// - Accepts one 32-bit word stream per port with a valid/ready handshake and writes each word into that port's input RAM.
// - Publishes the per-port write pointer (wr_add) for the scheduler's empty test, rd_add < wr_add.
// - Raises sched_enable once every port has finished loading.

---
 rtl/ingress_ram_writer.sv | 140 ++++++++++++++
 tb/tb_ingress_ram_writer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ingress_ram_writer.sv
// ============================================================================
// Module   : ingress_ram_writer
// Purpose  : Per-port ingress stage: valid/ready word streams into input RAMs,
//            publishing committed write pointers and a scheduler enable.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ingress_ram_writer #(
  parameter int NUM_PORTS = 3,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 12
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          restart_i,
  input  logic [NUM_PORTS-1:0]          in_valid_i,
  input  logic [NUM_PORTS*DATA_W-1:0]   in_data_i,
  input  logic [NUM_PORTS-1:0]          in_last_i,
  output logic [NUM_PORTS-1:0]          in_ready_o,
  output logic [NUM_PORTS-1:0]          ram_wren_o,
  output logic [NUM_PORTS*ADDR_W-1:0]   ram_wr_add_o,
  output logic [NUM_PORTS*DATA_W-1:0]   ram_wr_data_o,
  output logic [NUM_PORTS*ADDR_W-1:0]   wr_add_o,
  output logic [NUM_PORTS-1:0]          overflow_o,
  output logic                          sched_enable_o
);

  localparam logic [1:0]        ST_FILL = 2'd0;
  localparam logic [1:0]        ST_DONE = 2'd1;
  localparam logic [1:0]        ST_FULL = 2'd2;
  localparam logic [ADDR_W-1:0] CAP     = '1;

  // Holds in_ready low while reset is asserted and until the first edge after.
  logic                 alive_q;
  logic                 sched_q;
  logic                 sched_d;
  logic [NUM_PORTS-1:0] port_fill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive_q <= 1'b0;
      sched_q <= 1'b0;
    end else begin
      alive_q <= 1'b1;
      sched_q <= sched_d;
    end
  end

  always_comb begin
    sched_d = sched_q | ~(|port_fill);
    if (restart_i) begin
      sched_d = 1'b0;
    end
  end

  assign sched_enable_o = sched_q;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [ADDR_W-1:0] wr_add_q;
    logic [ADDR_W-1:0] wr_add_d;
    logic              ovf_q;
    logic              ovf_d;
    logic              wren_q;
    logic [ADDR_W-1:0] ram_add_q;
    logic [DATA_W-1:0] ram_data_q;
    logic              ready;
    logic              accept;

    // State register plus the one-cycle RAM write pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q    <= ST_FILL;
        wr_add_q   <= '0;
        ovf_q      <= 1'b0;
        wren_q     <= 1'b0;
        ram_add_q  <= '0;
        ram_data_q <= '0;
      end else begin
        state_q  <= state_d;
        wr_add_q <= wr_add_d;
        ovf_q    <= ovf_d;
        wren_q   <= accept;
        if (accept) begin
          ram_add_q  <= wr_add_q;
          ram_data_q <= in_data_i[p*DATA_W +: DATA_W];
        end
      end
    end

    // A write accepted alongside restart still reaches the RAM but is not counted.
    always_comb begin
      state_d  = state_q;
      wr_add_d = wr_add_q;
      ovf_d    = ovf_q;
      if (restart_i) begin
        state_d  = ST_FILL;
        wr_add_d = '0;
        ovf_d    = 1'b0;
      end else begin
        case (state_q)
          ST_FILL: begin
            if (accept) begin
              wr_add_d = wr_add_q + 1'b1;
              if (in_last_i[p]) begin
                state_d = ST_DONE;
              end else if ((wr_add_q + 1'b1) == CAP) begin
                state_d = ST_FULL;
              end
            end
          end
          ST_FULL: begin
            if (in_valid_i[p]) begin
              ovf_d = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end

    always_comb begin
      ready        = alive_q & (state_q == ST_FILL) & (wr_add_q != CAP);
      accept       = in_valid_i[p] & ready;
      port_fill[p] = (state_q == ST_FILL);
    end

    assign in_ready_o[p]                       = ready;
    assign ram_wren_o[p]                       = wren_q;
    assign ram_wr_add_o[p*ADDR_W +: ADDR_W]    = ram_add_q;
    assign ram_wr_data_o[p*DATA_W +: DATA_W]   = ram_data_q;
    assign wr_add_o[p*ADDR_W +: ADDR_W]        = wr_add_q;
    assign overflow_o[p]                       = ovf_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_ingress_ram_writer.sv
// ============================================================================
// Module   : tb_ingress_ram_writer
// Purpose  : Scoreboard bench for ingress_ram_writer (directed loads).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ingress_ram_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        restart = 1'b0;
  logic [2:0]  in_valid = '0;
  logic [95:0] in_data = '0;
  logic [2:0]  in_last = '0;
  logic [2:0]  in_ready;
  logic [2:0]  ram_wren;
  logic [35:0] ram_wr_add;
  logic [95:0] ram_wr_data;
  logic [35:0] wr_add;
  logic [2:0]  overflow;
  logic        sched_enable;

  int checks = 0;
  int failures = 0;

  // Model: 0 = filling, 1 = done, 2 = full
  int   m_st[3];
  int   m_wr[3];
  logic m_ovf[3];
  logic m_sched;
  logic m_alive;
  logic [43:0] sbq[3][$];

  ingress_ram_writer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .restart_i      (restart),
    .in_valid_i     (in_valid),
    .in_data_i      (in_data),
    .in_last_i      (in_last),
    .in_ready_o     (in_ready),
    .ram_wren_o     (ram_wren),
    .ram_wr_add_o   (ram_wr_add),
    .ram_wr_data_o  (ram_wr_data),
    .wr_add_o       (wr_add),
    .overflow_o     (overflow),
    .sched_enable_o (sched_enable)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic mrdy(input int p);
    return m_alive && (m_st[p] == 0) && (m_wr[p] < 4095);
  endfunction

  function automatic logic [31:0] mkword(input int p, input int idx);
    return 32'hA000_0000 + (p << 24) + idx;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 3; p++) begin
      m_st[p] = 0; m_wr[p] = 0; m_ovf[p] = 1'b0;
    end
    m_sched = 1'b0;
  endtask

  // One clock of stimulus; model advances to the values after the edge.
  task automatic step(input logic [2:0] v, input logic [2:0] l, input logic rs);
    int   n_st[3];
    int   n_wr[3];
    logic n_ovf[3];
    logic n_sched;
    logic all_nf;
    restart  = rs;
    in_valid = v;
    in_last  = l;
    for (int p = 0; p < 3; p++) in_data[p*32 +: 32] = mkword(p, m_wr[p]);
    @(negedge clk);
    all_nf = 1'b1;
    for (int p = 0; p < 3; p++) begin
      chk("in_ready", {31'b0, in_ready[p]}, {31'b0, mrdy(p)});
      chk("wr_add", {20'b0, wr_add[p*12 +: 12]}, m_wr[p]);
      chk("overflow", {31'b0, overflow[p]}, {31'b0, m_ovf[p]});
      if (m_st[p] == 0) all_nf = 1'b0;
    end
    chk("sched_enable", {31'b0, sched_enable}, {31'b0, m_sched});
    n_sched = rs ? 1'b0 : (m_sched | all_nf);
    for (int p = 0; p < 3; p++) begin
      n_st[p] = m_st[p]; n_wr[p] = m_wr[p]; n_ovf[p] = m_ovf[p];
      if (v[p] && mrdy(p)) sbq[p].push_back({m_wr[p][11:0], mkword(p, m_wr[p])});
      if (rs) begin
        n_st[p] = 0; n_wr[p] = 0; n_ovf[p] = 1'b0;
      end else if (v[p] && mrdy(p)) begin
        n_wr[p] = m_wr[p] + 1;
        if (l[p]) n_st[p] = 1;
        else if (n_wr[p] == 4095) n_st[p] = 2;
      end else if (m_st[p] == 2 && v[p]) begin
        n_ovf[p] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    for (int p = 0; p < 3; p++) begin
      m_st[p] = n_st[p]; m_wr[p] = n_wr[p]; m_ovf[p] = n_ovf[p];
    end
    m_sched  = n_sched;
    in_valid = '0;
    in_last  = '0;
    restart  = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_in_ready"}, {29'b0, in_ready}, 0);
    chk({tag, "_ram_wren"}, {29'b0, ram_wren}, 0);
    chk({tag, "_ram_wr_add"}, ram_wr_add[31:0] | {28'b0, ram_wr_add[35:32]}, 0);
    chk({tag, "_ram_wr_data"}, ram_wr_data[31:0] | ram_wr_data[63:32] | ram_wr_data[95:64], 0);
    chk({tag, "_wr_add"}, wr_add[31:0] | {28'b0, wr_add[35:32]}, 0);
    chk({tag, "_overflow"}, {29'b0, overflow}, 0);
    chk({tag, "_sched"}, {31'b0, sched_enable}, 0);
  endtask

  task automatic chk_wr(input string tag, input int a0, input int a1, input int a2);
    chk({tag, "_wr_add0"}, {20'b0, wr_add[11:0]}, a0);
    chk({tag, "_wr_add1"}, {20'b0, wr_add[23:12]}, a1);
    chk({tag, "_wr_add2"}, {20'b0, wr_add[35:24]}, a2);
  endtask

  task automatic chk_drained(input string tag);
    for (int p = 0; p < 3; p++) chk({tag, "_pending_writes"}, sbq[p].size(), 0);
  endtask

  // Scoreboard monitor: every RAM write must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int p = 0; p < 3; p++) begin
        if (ram_wren[p]) begin
          if (sbq[p].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write port=%0d addr=%0h expected=none", p, ram_wr_add[p*12 +: 12]);
          end else begin
            logic [43:0] e;
            e = sbq[p].pop_front();
            chk("ram_wr_add", {20'b0, ram_wr_add[p*12 +: 12]}, {20'b0, e[43:32]});
            chk("ram_wr_data", ram_wr_data[p*32 +: 32], e[31:0]);
          end
        end
      end
    end
  end

  initial begin
    m_alive = 1'b0;
    model_reset();
    #12;
    chk_zero("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1; m_alive = 1'b1;

    // All ports, 4 words, last on the 4th
    for (int i = 0; i < 4; i++) step(3'b111, (i == 3) ? 3'b111 : 3'b000, 1'b0);
    chk("t1_sched_before", {31'b0, sched_enable}, 0);
    step(3'b000, 3'b000, 1'b0);
    chk("t1_sched_after", {31'b0, sched_enable}, 1);
    step(3'b000, 3'b000, 1'b0);
    chk_wr("t1", 4, 4, 4);
    chk_drained("t1");
    step(3'b000, 3'b000, 1'b1);

    // Staggered: 2, 7, 1 words
    for (int c = 0; c < 40; c++) begin
      logic [2:0] v, l;
      v[0] = (m_wr[0] < 2) && (c % 3 == 1);
      v[1] = (m_wr[1] < 7) && (c % 2 == 0);
      v[2] = (m_wr[2] < 1) && (c == 5);
      l[0] = (m_wr[0] == 1);
      l[1] = (m_wr[1] == 6);
      l[2] = (m_wr[2] == 0);
      if (c == 8) chk("t2_sched_waits_port1", {31'b0, sched_enable}, 0);
      step(v, l, 1'b0);
    end
    chk_wr("t2", 2, 7, 1);
    chk("t2_sched", {31'b0, sched_enable}, 1);
    chk_drained("t2");
    step(3'b000, 3'b000, 1'b1);

    // Port0 fills to capacity without last, then overflows
    for (int i = 0; i < 4095; i++) step(3'b001, 3'b000, 1'b0);
    chk("t3_ready0", {31'b0, in_ready[0]}, 0);
    chk("t3_ovf_before", {29'b0, overflow}, 0);
    step(3'b001, 3'b000, 1'b0);
    step(3'b000, 3'b000, 1'b0);
    chk("t3_ovf", {29'b0, overflow}, 3'b001);
    chk("t3_ready12", {30'b0, in_ready[2:1]}, 2'b11);
    chk_wr("t3", 4095, 0, 0);
    chk_drained("t3");
    step(3'b000, 3'b000, 1'b1);
    chk("t3_ovf_cleared", {29'b0, overflow}, 0);

    // Capacity and last on the same word: done wins
    for (int i = 0; i < 4095; i++) step(3'b001, (i == 4094) ? 3'b001 : 3'b000, 1'b0);
    step(3'b001, 3'b000, 1'b0);
    step(3'b000, 3'b000, 1'b0);
    chk("t4_ovf", {29'b0, overflow}, 0);
    chk("t4_ready0", {31'b0, in_ready[0]}, 0);
    chk_wr("t4", 4095, 0, 0);
    chk_drained("t4");
    step(3'b000, 3'b000, 1'b1);

    // Reset mid-load after 10 words
    for (int i = 0; i < 10; i++) step(3'b001, 3'b000, 1'b0);
    step(3'b000, 3'b000, 1'b0);
    chk_wr("t5_pre", 10, 0, 0);
    chk_drained("t5");
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("t5_async");
    m_alive = 1'b0;
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1; m_alive = 1'b1;
    step(3'b111, 3'b000, 1'b0);
    step(3'b111, 3'b111, 1'b0);
    step(3'b000, 3'b000, 1'b0);
    step(3'b000, 3'b000, 1'b0);
    chk_wr("t5_post", 2, 2, 2);
    chk("t5_sched", {31'b0, sched_enable}, 1);

    // Restart and reload 3 words per port
    step(3'b000, 3'b000, 1'b1);
    chk_wr("t6_cleared", 0, 0, 0);
    chk("t6_sched_drop", {31'b0, sched_enable}, 0);
    for (int i = 0; i < 3; i++) step(3'b111, (i == 2) ? 3'b111 : 3'b000, 1'b0);
    step(3'b000, 3'b000, 1'b0);
    step(3'b000, 3'b000, 1'b0);
    chk_wr("t6", 3, 3, 3);
    chk("t6_sched_reassert", {31'b0, sched_enable}, 1);
    chk("t6_ovf", {29'b0, overflow}, 0);
    chk_drained("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
